// File: rtl/digital_clk_pkg.sv
// Shared constants, control types, program ROM image and seven-segment
// glyph table for the classroom MIPS board top level.
package digital_clk_pkg;

  localparam int unsigned ROM_WORDS = 64;
  localparam int unsigned RAM_WORDS = 64;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    mem_to_reg;
    logic    use_imm;
    logic    dst_rd;
    logic    branch;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;

  // Fixed program: $8 starts at 1 and doubles each pass through a
  // store/load loop, with $9 picking up the stored value.
  localparam logic [31:0] PROGRAM [0:ROM_WORDS-1] = '{
    0:       32'h2008_0001,  // addi $8,$0,1
    1:       32'h0108_4020,  // add  $8,$8,$8
    2:       32'hAC08_0000,  // sw   $8,0($0)
    3:       32'h8C09_0000,  // lw   $9,0($0)
    4:       32'h0800_0001,  // j    0x04
    default: 32'h0000_0000
  };

  // Active-low hex glyph, bit order {g,f,e,d,c,b,a}; b and d lowercase.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Main decoder; unsupported encodings fall out as all-zero control (nop).
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        c.dst_rd = 1'b1;
        c.reg_we = 1'b1;
        case (fn)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c.reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        c.reg_we  = 1'b1;
        c.use_imm = 1'b1;
      end
      OP_LW: begin
        c.reg_we     = 1'b1;
        c.use_imm    = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        c.mem_we  = 1'b1;
        c.use_imm = 1'b1;
      end
      OP_BEQ:  c.branch = 1'b1;
      OP_J:    c.jump   = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/digital_clk_seg7_scan.sv
// Four-digit multiplexed seven-segment driver. The digit index advances
// on each rising edge of the sampled scan strobe.
module seg7_scan
  import digital_clk_pkg::*;
(
  input  logic        pipeclk,
  input  logic        reset,
  input  logic        clk,
  input  logic [15:0] disp,
  output logic [3:0]  anodes,
  output logic [6:0]  cathodes
);

  logic [1:0] d;
  logic       clk_q;
  logic [3:0] nib;

  // Strobe history and digit index; the index steps on a 0->1 strobe change.
  always_ff @(posedge pipeclk) begin
    if (!reset) begin
      d     <= '0;
      clk_q <= 1'b0;
    end else begin
      clk_q <= clk;
      if (clk && !clk_q) begin
        d <= d + 2'd1;
      end
    end
  end

  // Digit enable and glyph for the currently selected nibble.
  always_comb begin
    nib      = disp[{d, 2'b00} +: 4];
    anodes   = ~(4'b0001 << d);
    cathodes = seg7_glyph(nib);
  end

endmodule

// File: rtl/digital_clk.sv
// Classroom MIPS board top: single-cycle MIPS-subset core with program ROM,
// data RAM, register/PC display select and seven-segment scan.
module digital_clk
  import digital_clk_pkg::*;
(
  input  logic       pipeclk,
  input  logic       reset,
  input  logic       clk,
  input  logic [4:0] regsel,
  input  logic       pcsel,
  output logic [6:0] cathodes,
  output logic [3:0] anodes,
  output logic [3:0] w3,
  output logic [3:0] w4,
  output logic [3:0] w7,
  output logic [3:0] w8
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] regs [0:31];
  logic [31:0] ram  [0:RAM_WORDS-1];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  fn;
  logic [31:0] sext;
  ctrl_t       ctrl;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wa;
  logic        equal;
  logic [31:0] disp;
  logic        unused_bits;

  assign instr    = PROGRAM[pc[7:2]];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign fn       = instr[5:0];
  assign sext     = {{16{instr[15]}}, instr[15:0]};
  assign ctrl     = decode(op, fn);
  assign pc_plus4 = pc + 32'd4;

  // Register read ports; $0 is hard-wired to zero.
  always_comb begin
    rs_val = (rs == 5'd0) ? '0 : regs[rs];
    rt_val = (rt == 5'd0) ? '0 : regs[rt];
  end

  // ALU: wrapping arithmetic, signed set-less-than.
  always_comb begin
    alu_b = ctrl.use_imm ? sext : rt_val;
    case (ctrl.alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'd0, ($signed(rs_val) < $signed(alu_b))};
      default: alu_y = rs_val + alu_b;
    endcase
  end

  // Asynchronous RAM read and write-back selection.
  always_comb begin
    mem_rdata = ram[alu_y[7:2]];
    wb_data   = ctrl.mem_to_reg ? mem_rdata : alu_y;
    wa        = ctrl.dst_rd ? rd : rt;
  end

  // Next-PC selection: jump, taken branch or fall-through.
  always_comb begin
    equal = (rs_val == rt_val);
    if (ctrl.jump) begin
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (ctrl.branch && equal) begin
      pc_next = pc_plus4 + (sext << 2);
    end else begin
      pc_next = pc_plus4;
    end
  end

  // Program counter.
  always_ff @(posedge pipeclk) begin
    if (!reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  // Register file; reset clears all 32 entries, writes to $0 are dropped.
  always_ff @(posedge pipeclk) begin
    if (!reset) begin
      regs <= '{default: '0};
    end else if (ctrl.reg_we && (wa != 5'd0)) begin
      regs[wa] <= wb_data;
    end
  end

  // Data RAM write; contents survive reset, and a store in flight at reset is dropped.
  always_ff @(posedge pipeclk) begin
    if (reset && ctrl.mem_we) begin
      ram[alu_y[7:2]] <= rt_val;
    end
  end

  // Display source select and simulation nibble taps.
  always_comb begin
    disp = pcsel ? pc : regs[regsel];
    w3   = disp[11:8];
    w4   = disp[15:12];
    w7   = disp[27:24];
    w8   = disp[31:28];
  end

  assign unused_bits = ^{instr[10:6], disp[23:16]};

  seg7_scan u_scan (
    .pipeclk  (pipeclk),
    .reset    (reset),
    .clk      (clk),
    .disp     (disp[15:0]),
    .anodes   (anodes),
    .cathodes (cathodes)
  );

endmodule

// File: tb/tb_digital_clk.sv
// Self-checking bench for digital_clk: reset state, table of program
// checkpoints, display scan sequence and a mid-program reset.
module tb_digital_clk;

  logic       pipeclk = 1'b0;
  logic       reset;
  logic       clk;
  logic [4:0] regsel;
  logic       pcsel;
  logic [6:0] cathodes;
  logic [3:0] anodes;
  logic [3:0] w3, w4, w7, w8;

  digital_clk dut (
    .pipeclk  (pipeclk),
    .reset    (reset),
    .clk      (clk),
    .regsel   (regsel),
    .pcsel    (pcsel),
    .cathodes (cathodes),
    .anodes   (anodes),
    .w3       (w3),
    .w4       (w4),
    .w7       (w7),
    .w8       (w8)
  );

  always #5 pipeclk = ~pipeclk;

  localparam int K_TAPS = 0;
  localparam int K_AN   = 1;
  localparam int K_CATH = 2;
  localparam int K_RAM0 = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    int          n;
    logic [4:0]  rsel;
    logic        psel;
    logic [31:0] disp;
    string       name;
  } vec_t;

  sb_t        sb[$];
  vec_t       vecs [16];
  logic [6:0] glyph_tab [16];
  int         total = 0;
  int         bad   = 0;
  int         n     = 0;   // instructions executed since reset release

  function automatic logic [31:0] taps_of(input logic [31:0] v);
    return {16'h0, v[31:28], v[27:24], v[15:12], v[11:8]};
  endfunction

  function automatic logic [31:0] actual_of(input int kind);
    case (kind)
      K_TAPS:  return {16'h0, w8, w7, w4, w3};
      K_AN:    return {28'h0, anodes};
      K_CATH:  return {25'h0, cathodes};
      default: return dut.ram[0];
    endcase
  endfunction

  // Program model: PC after n instructions.
  function automatic logic [31:0] exp_pc(input int cnt);
    if (cnt == 0) return 32'h0;
    return 32'(4 + 4 * ((cnt - 1) % 4));
  endfunction

  task automatic push(input string name, input int kind, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic push_disp(input string name, input logic [31:0] v, input logic [1:0] d);
    logic [31:0] sh;
    logic [3:0]  nib;
    sh  = v >> (4 * d);
    nib = sh[3:0];
    push({name, "_taps"}, K_TAPS, taps_of(v));
    push({name, "_an"}, K_AN, {28'h0, ~(4'b0001 << d)});
    push({name, "_cath"}, K_CATH, {25'h0, glyph_tab[nib]});
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = actual_of(e.kind);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge pipeclk);
    if (reset) n++;
    #1;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcv;
    logic [3:0]  nib;
    logic [1:0]  dexp;

    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0]  = '{1,   5'd8, 1'b0, 32'h0000_0001, "r8_n1"};
    vecs[1]  = '{1,   5'd8, 1'b1, 32'h0000_0004, "pc_n1"};
    vecs[2]  = '{2,   5'd8, 1'b0, 32'h0000_0002, "r8_n2"};
    vecs[3]  = '{3,   5'd0, 1'b1, 32'h0000_000C, "pc_n3"};
    vecs[4]  = '{4,   5'd9, 1'b0, 32'h0000_0002, "r9_n4"};
    vecs[5]  = '{4,   5'd8, 1'b1, 32'h0000_0010, "pc_n4"};
    vecs[6]  = '{5,   5'd8, 1'b1, 32'h0000_0004, "pc_jump"};
    vecs[7]  = '{6,   5'd8, 1'b0, 32'h0000_0004, "r8_n6"};
    vecs[8]  = '{18,  5'd8, 1'b0, 32'h0000_0020, "r8_n18"};
    vecs[9]  = '{18,  5'd9, 1'b0, 32'h0000_0010, "r9_n18"};
    vecs[10] = '{18,  5'd0, 1'b0, 32'h0000_0000, "r0_n18"};
    vecs[11] = '{30,  5'd8, 1'b0, 32'h0000_0100, "r8_n30"};
    vecs[12] = '{98,  5'd8, 1'b0, 32'h0200_0000, "r8_n98"};
    vecs[13] = '{122, 5'd8, 1'b0, 32'h8000_0000, "r8_n122"};
    vecs[14] = '{122, 5'd9, 1'b0, 32'h4000_0000, "r9_n122"};
    vecs[15] = '{126, 5'd8, 1'b0, 32'h0000_0000, "r8_wrap"};

    // Reset held for five cycles.
    reset  = 1'b0;
    clk    = 1'b0;
    regsel = 5'd8;
    pcsel  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      push_disp("reset_hold", 32'h0, 2'd0);
      drain();
    end
    pcsel = 1'b1;
    #1;
    push_disp("reset_pc", 32'h0, 2'd0);
    drain();
    pcsel = 1'b0;
    reset = 1'b1;

    // Program checkpoints.
    for (int i = 0; i < 16; i++) begin
      run_to(vecs[i].n);
      regsel = vecs[i].rsel;
      pcsel  = vecs[i].psel;
      push_disp(vecs[i].name, vecs[i].disp, 2'd0);
      #1;
      drain();
    end

    // Display scan: five strobe rises, plus a held-high strobe that must not advance.
    pcsel = 1'b1;
    push("scan_start_an", K_AN, 32'hE);
    drain();
    for (int k = 1; k <= 5; k++) begin
      clk = 1'b1;
      tick();
      #1;
      dexp = 2'(k % 4);
      pcv  = exp_pc(n) >> (4 * dexp);
      nib  = pcv[3:0];
      push($sformatf("scan_an_%0d", k), K_AN, {28'h0, ~(4'b0001 << dexp)});
      push($sformatf("scan_cath_%0d", k), K_CATH, {25'h0, glyph_tab[nib]});
      drain();
      if (k == 2) begin
        tick();
        #1;
        push("scan_hold_an", K_AN, {28'h0, ~(4'b0001 << dexp)});
        drain();
      end
      clk = 1'b0;
      tick();
    end

    // Fresh run, then reset mid-loop.
    reset = 1'b0;
    tick();
    tick();
    n     = 0;
    reset = 1'b1;
    run_to(21);
    reset = 1'b0;
    pcsel = 1'b1;
    tick();
    #1;
    push_disp("midrst_pc", 32'h0, 2'd0);
    push("midrst_ram0", K_RAM0, 32'h20);
    drain();
    tick();
    n     = 0;
    reset = 1'b1;
    pcsel = 1'b0;
    regsel = 5'd8;
    run_to(1);
    #1;
    push_disp("restart_r8_n1", 32'h1, 2'd0);
    push("restart_ram0_n1", K_RAM0, 32'h20);
    drain();
    run_to(2);
    #1;
    push_disp("restart_r8_n2", 32'h2, 2'd0);
    push("restart_ram0_n2", K_RAM0, 32'h20);
    drain();
    run_to(3);
    #1;
    push("restart_ram0_n3", K_RAM0, 32'h2);
    pcsel = 1'b1;
    #1;
    push_disp("restart_pc_n3", 32'h0000_000C, 2'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
